arm7tdmi_prefetch: RTL and testbench
====================================

ARM7TDMI_PREFETCH -- requirements
Module: arm7tdmi_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, fetch address after reset/flush.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports fetch_en  input  1  (enable issue); thumb_mode  input  1  (state for next issue); flush  input  1; branch_taken  input  1; branch_target  input  32.
REQ-006 SHALL have ports mem_addr  output  32; mem_re  output  1 (request); mem_rdata  input  32; mem_ready  input  1 (data valid, completes the request).
REQ-007 SHALL have ports instruction  output  32; pc_out  output  32; instr_thumb  output  1; instr_valid  output  1; instr_ready  input  1 (decode accepts).

Function
REQ-008 SHALL allow at most one outstanding memory request; mem_addr and mem_re SHALL hold stable from assertion until the cycle mem_ready is high.
REQ-009 SHALL issue a new request only when fetch_en=1, no request outstanding or completing this cycle, no flush/branch this cycle, and (queue count + outstanding) < DEPTH.
REQ-010 SHALL fetch address fa: after issue, fa += 2 if thumb_mode else fa += 4; mem_addr = {fa[31:2],2'b00} word-aligned.
REQ-011 SHALL latch thumb_mode and fa with each request; on completion push {instruction, pc, thumb}; Thumb instruction = zero-extended mem_rdata[31:16] if fa[1]=1 else mem_rdata[15:0]; ARM = mem_rdata.
REQ-012 SHALL use FSM IDLE (no request), BUSY (request outstanding, data kept), DISCARD (request outstanding, data dropped).
REQ-013 SHALL transition IDLE->BUSY on issue; BUSY->IDLE on mem_ready; BUSY->DISCARD on flush/branch without mem_ready; DISCARD->IDLE on mem_ready (data dropped).
REQ-014 SHALL on branch_taken: empty queue, fa <= branch_target with bit 0 cleared (bits [1:0] cleared if thumb_mode=0), response in flight that cycle or later discarded.
REQ-015 SHALL on flush: same as branch but fa <= RESET_VECTOR; flush has priority over branch_taken when both high.
REQ-016 SHALL present queue head on instruction/pc_out/instr_thumb with instr_valid=1 when not empty; pop when instr_valid & instr_ready.
REQ-017 SHALL allow push and pop in the same cycle (count unchanged), including at count=DEPTH-1 with issue credit freed.
REQ-018 SHALL hold head outputs stable while instr_valid=1 and instr_ready=0.
REQ-019 SHALL give latency: mem_ready in cycle N -> instr_valid=1 in cycle N+1 when queue was empty.
REQ-020 SHALL deassert instr_valid in the cycle after flush/branch; the popped-by-flush entry is not counted as consumed.
REQ-021 SHALL wrap fa modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

Reset
REQ-022 SHALL on rst=1: state IDLE, fa=RESET_VECTOR, queue empty, mem_re=0, instr_valid=0, instruction=0, pc_out=0, instr_thumb=0.
REQ-023 SHALL on rst mid-request ignore a mem_ready arriving in the following cycles as IDLE has no outstanding request (memory must also be reset).

Structure
REQ-024 SHALL place fetch_state_t, fetch_entry_t {instr, pc, thumb} and DEFAULT_PREFETCH_DEPTH in arm7tdmi_pkg.
REQ-025 SHALL instantiate one sub-module arm7tdmi_fifo (parametrised width/depth, sync clear) for the queue.

Verification
REQ-026 SHALL cover: reset, fetch_en=1, ARM, mem_ready after 1 cycle, instr_ready=1 -> pc_out 0,4,8,... with instruction = memory words, mem_addr 0,4,8.
REQ-027 SHALL cover: Thumb, word at 0 = 32'hBEEF_CAFE -> entries pc 0 instr 32'h0000_CAFE, pc 2 instr 32'h0000_BEEF, both instr_thumb=1.
REQ-028 SHALL cover: DEPTH=4, instr_ready=0 -> exactly 4 completions, mem_re stays 0 thereafter; one pop -> one new request.
REQ-029 SHALL cover: branch_taken to 32'h100 while BUSY, mem_ready 2 cycles later -> stale data never appears; next pc_out=32'h100.
REQ-030 SHALL cover: flush and branch_taken same cycle -> next mem_addr = RESET_VECTOR, queue empty, instr_valid=0.
REQ-031 SHALL cover: branch_target 32'hFFFF_FFFC ARM -> pc_out 32'hFFFF_FFFC then 32'h0000_0000.

Source files
------------

// File: rtl/arm7tdmi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm7tdmi_pkg
// Description : Shared types and constants for the ARM7TDMI prefetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package arm7tdmi_pkg;

    localparam int DEFAULT_PREFETCH_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        thumb;
    } fetch_entry_t;

    // A Thumb fetch reads a whole word; the halfword is picked by address bit 1.
    function automatic logic [31:0] thumb_select(input logic [31:0] word, input logic half_hi);
        return half_hi ? {16'h0000, word[31:16]} : {16'h0000, word[15:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/arm7tdmi_fifo.sv
`default_nettype none
// ============================================================================
// Module      : arm7tdmi_fifo
// Description : Power-of-two depth FIFO with synchronous clear and
//               simultaneous push/pop, used as the prefetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
module arm7tdmi_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam int              c_CW   = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A pop in the same cycle frees the slot a full-queue push needs.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != c_FULL) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count <= r_count + c_CW'(w_do_push) - c_CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_clr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/arm7tdmi_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : arm7tdmi_prefetch
// Description : ARM/Thumb instruction prefetch unit with a single outstanding
//               memory request, branch/flush redirect and a decode queue.
// Revision    : 1.0 - initial release
// ============================================================================
module arm7tdmi_prefetch
    import arm7tdmi_pkg::*;
#(
    parameter int          DEPTH        = DEFAULT_PREFETCH_DEPTH,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        thumb_mode,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        instr_thumb,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam int              c_CW    = $clog2(DEPTH) + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [31:0]     r_fa;
    logic [31:0]     r_req_fa;
    logic            r_req_thumb;
    logic            w_redirect;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic [c_CW-1:0] w_count;
    logic [31:0]     w_step;
    logic [31:0]     w_target;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    assign w_redirect = flush | branch_taken;
    assign w_step     = thumb_mode ? 32'd2 : 32'd4;
    assign w_target   = branch_target & (thumb_mode ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Issue is only considered from IDLE, so nothing is outstanding and the
    // queue count alone bounds the credit.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (fetch_en && !w_redirect && (w_count < c_DEPTH)) begin
                    w_issue      = 1'b1;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    w_push       = !w_redirect;
                    w_state_next = ST_IDLE;
                end else if (w_redirect) begin
                    w_state_next = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (mem_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fa        <= RESET_VECTOR;
            r_req_fa    <= '0;
            r_req_thumb <= 1'b0;
        end else if (flush) begin
            r_fa <= RESET_VECTOR;
        end else if (branch_taken) begin
            r_fa <= w_target;
        end else if (w_issue) begin
            r_fa        <= r_fa + w_step;
            r_req_fa    <= r_fa;
            r_req_thumb <= thumb_mode;
        end
    end

    assign mem_re   = (r_state != ST_IDLE);
    assign mem_addr = mem_re ? {r_req_fa[31:2], 2'b00} : 32'h0000_0000;

    always_comb begin
        w_push_entry.instr = r_req_thumb ? thumb_select(mem_rdata, r_req_fa[1]) : mem_rdata;
        w_push_entry.pc    = r_req_fa;
        w_push_entry.thumb = r_req_thumb;
    end

    assign w_pop = instr_valid & instr_ready;

    arm7tdmi_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_redirect),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign instr_valid = !w_empty;
    assign instruction = instr_valid ? w_head.instr : 32'h0000_0000;
    assign pc_out      = instr_valid ? w_head.pc    : 32'h0000_0000;
    assign instr_thumb = instr_valid & w_head.thumb;

endmodule
`default_nettype wire

// File: tb/tb_arm7tdmi_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_arm7tdmi_prefetch
// Description : Self-checking bench: queue-based reference model, random
//               memory latency, directed scenarios plus random redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arm7tdmi_prefetch;

    localparam int          c_DEPTH = 4;
    localparam logic [31:0] c_RV    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, fetch_en, thumb_mode, flush, branch_taken, instr_ready;
    logic [31:0] branch_target;
    logic [31:0] mem_addr, mem_rdata, instruction, pc_out;
    logic        mem_re, mem_ready, instr_thumb, instr_valid;

    arm7tdmi_prefetch #(.DEPTH(c_DEPTH), .RESET_VECTOR(c_RV)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .thumb_mode(thumb_mode),
        .flush(flush), .branch_taken(branch_taken), .branch_target(branch_target),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .instruction(instruction), .pc_out(pc_out), .instr_thumb(instr_thumb),
        .instr_valid(instr_valid), .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        thumb;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    int          n_req = 0;
    int          resp_lo = 1;
    int          resp_hi = 1;
    bit          started = 0;
    exp_t        mq[$];
    logic        m_out, m_stale, m_req_thumb, obs_prev;
    logic [31:0] m_fa, m_req_fa;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'hBEEF_CAFE;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] fa, input logic th);
        logic [31:0] w;
        w = mem_word({fa[31:2], 2'b00});
        if (!th) return w;
        return fa[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: answers each request after a random number of cycles.
    initial begin : g_memory
        bit active;
        int wait_cnt;
        active    = 0;
        wait_cnt  = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!mem_re) begin
                mem_ready = 1'b0;
                active    = 0;
            end else begin
                if (!active) begin
                    active   = 1;
                    wait_cnt = $urandom_range(resp_hi, resp_lo);
                end else if (wait_cnt > 0) begin
                    wait_cnt--;
                end
                mem_ready = (wait_cnt == 0);
                mem_rdata = mem_ready ? mem_word(mem_addr) : $urandom;
            end
        end
    end

    // Reference model: one outstanding fetch, a queue of expected entries.
    initial begin : g_model
        int   sz0;
        logic done, redir, was_out;
        forever begin
            @(posedge clk);
            if (mem_re && !obs_prev) n_req++;
            obs_prev = mem_re;
            if (rst) begin
                started     = 1;
                mq.delete();
                m_out       = 0;
                m_stale     = 0;
                m_fa        = c_RV;
                m_req_fa    = 0;
                m_req_thumb = 0;
            end else begin
                sz0     = mq.size();
                done    = m_out && mem_ready;
                redir   = flush || branch_taken;
                was_out = m_out;
                if (redir) begin
                    mq.delete();
                    m_stale = m_out && !done;
                    m_out   = m_out && !done;
                    m_fa    = flush ? c_RV
                                    : (thumb_mode ? (branch_target & ~32'h1) : (branch_target & ~32'h3));
                end else begin
                    if (sz0 > 0 && instr_ready) void'(mq.pop_front());
                    if (done) begin
                        if (!m_stale) mq.push_back('{exp_instr(m_req_fa, m_req_thumb), m_req_fa, m_req_thumb});
                        m_stale = 0;
                        m_out   = 0;
                    end
                    if (fetch_en && !was_out && sz0 < c_DEPTH) begin
                        m_out       = 1;
                        m_req_fa    = m_fa;
                        m_req_thumb = thumb_mode;
                        m_fa        = m_fa + (thumb_mode ? 32'd2 : 32'd4);
                    end
                end
            end
        end
    end

    // Compare DUT against model every cycle, away from the active edge.
    initial begin : g_compare
        forever begin
            @(negedge clk);
            if (started) begin
                chk("mem_re", {31'b0, mem_re}, {31'b0, m_out});
                if (m_out) chk("mem_addr", mem_addr, {m_req_fa[31:2], 2'b00});
                chk("instr_valid", {31'b0, instr_valid}, {31'b0, (mq.size() > 0)});
                if (mq.size() > 0) begin
                    chk("instruction", instruction, mq[0].instr);
                    chk("pc_out", pc_out, mq[0].pc);
                    chk("instr_thumb", {31'b0, instr_thumb}, {31'b0, mq[0].thumb});
                end
            end
        end
    end

    task automatic wait_valid(input int maxc, input string what);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!instr_valid && k < maxc);
        if (!instr_valid) begin
            total++;
            bad++;
            $display("FAIL %s: instr_valid actual=0 required=1 within %0d cycles", what, maxc);
        end
    endtask

    task automatic wait_re_rise(input int maxc, input string what);
        int   k;
        logic prev;
        k    = 0;
        prev = mem_re;
        do begin
            @(negedge clk);
            k++;
            if (mem_re && !prev) return;
            prev = mem_re;
        end while (k < maxc);
        total++;
        bad++;
        $display("FAIL %s: new mem_re actual=none required=rise within %0d cycles", what, maxc);
    endtask

    task automatic redirect(input logic fl, input logic br, input logic [31:0] tgt);
        flush         = fl;
        branch_taken  = br;
        branch_target = tgt;
        @(negedge clk);
        flush         = 1'b0;
        branch_taken  = 1'b0;
    endtask

    initial begin : g_driver
        int snap, r;
        rst = 1'b1; fetch_en = 1'b0; thumb_mode = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0; instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_re", {31'b0, mem_re}, 32'd0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instruction", instruction, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_instr_thumb", {31'b0, instr_thumb}, 32'd0);

        // ARM stream from reset, memory answers one cycle after the request
        rst = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1;
        wait_valid(50, "arm0");
        chk("arm_pc0", pc_out, 32'h0);
        chk("arm_instr0", instruction, 32'hBEEF_CAFE);
        chk("arm_thumb0", {31'b0, instr_thumb}, 32'd0);
        wait_valid(50, "arm1");
        chk("arm_pc1", pc_out, 32'h4);
        chk("arm_instr1", instruction, mem_word(32'h4));
        wait_valid(50, "arm2");
        chk("arm_pc2", pc_out, 32'h8);

        // Thumb halfwords from the word at 0
        thumb_mode = 1'b1;
        redirect(1'b1, 1'b0, 32'h0);
        wait_valid(50, "thumb0");
        chk("thumb_pc0", pc_out, 32'h0);
        chk("thumb_instr0", instruction, 32'h0000_CAFE);
        chk("thumb_flag0", {31'b0, instr_thumb}, 32'd1);
        wait_valid(50, "thumb1");
        chk("thumb_pc1", pc_out, 32'h2);
        chk("thumb_instr1", instruction, 32'h0000_BEEF);
        chk("thumb_flag1", {31'b0, instr_thumb}, 32'd1);

        // Fill the queue with decode stalled
        thumb_mode = 1'b0; instr_ready = 1'b0; resp_lo = 0; resp_hi = 0;
        redirect(1'b1, 1'b0, 32'h0);
        snap = n_req;
        repeat (30) @(negedge clk);
        chk("fill_requests", n_req - snap, 32'd4);
        chk("fill_model_size", mq.size(), 32'd4);
        chk("fill_mem_re", {31'b0, mem_re}, 32'd0);
        chk("fill_head_pc", pc_out, 32'h0);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        snap = n_req;
        repeat (20) @(negedge clk);
        chk("refill_requests", n_req - snap, 32'd1);
        chk("refill_head_pc", pc_out, 32'h4);

        // Branch while a request is outstanding; its data must be dropped
        instr_ready = 1'b1; resp_lo = 2; resp_hi = 2;
        wait_re_rise(50, "busy_branch");
        redirect(1'b0, 1'b1, 32'h100);
        wait_valid(50, "branch100");
        chk("branch_pc", pc_out, 32'h100);
        chk("branch_instr", instruction, mem_word(32'h100));

        // Flush beats branch in the same cycle
        instr_ready = 1'b0; resp_lo = 0; resp_hi = 1;
        repeat (12) @(negedge clk);
        chk("pre_flush_valid", {31'b0, instr_valid}, 32'd1);
        redirect(1'b1, 1'b1, 32'h200);
        chk("flush_valid", {31'b0, instr_valid}, 32'd0);
        wait_re_rise(50, "flush_fetch");
        chk("flush_addr", mem_addr, c_RV);

        // Address wrap at the top of memory
        instr_ready = 1'b1; resp_lo = 0; resp_hi = 2;
        redirect(1'b0, 1'b1, 32'hFFFF_FFFC);
        wait_valid(50, "wrap0");
        chk("wrap_pc0", pc_out, 32'hFFFF_FFFC);
        chk("wrap_instr0", instruction, mem_word(32'hFFFF_FFFC));
        wait_valid(50, "wrap1");
        chk("wrap_pc1", pc_out, 32'h0);
        chk("wrap_instr1", instruction, 32'hBEEF_CAFE);

        // Reset in the middle of a request
        resp_lo = 2; resp_hi = 3;
        wait_re_rise(50, "mid_rst");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_mem_re", {31'b0, mem_re}, 32'd0);
        chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
        rst = 1'b0;

        // Random traffic with redirects and mode changes
        resp_lo = 0; resp_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            fetch_en    = ($urandom_range(9, 0) != 0);
            thumb_mode  = $urandom_range(1, 0);
            instr_ready = ($urandom_range(9, 0) < 7);
            r           = $urandom_range(99, 0);
            flush        = (r < 2) || (r == 99);
            branch_taken = (r >= 2 && r < 6) || (r == 99);
            branch_target = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15, 0))
                                                        : $urandom;
            @(negedge clk);
        end
        flush = 1'b0; branch_taken = 1'b0; instr_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
